// File: rtl/seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_checker: checks an incoming word stream against the Fibonacci          |
// | recurrence modulo 2^WIDTH. Revision: 1.0                                   |
// +----------------------------------------------------------------------------+
module seq_checker #(
   parameter int WIDTH       = 32,
   parameter bit STRICT_SEED = 1'b1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] seq_i,
   input  logic             seq_valid_i,
   output logic             locked_o,
   output logic             match_o,
   output logic             err_o,
   output logic [WIDTH-1:0] expected_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   typedef enum logic [1:0] {
      SEED_A = 2'd0,
      SEED_B = 2'd1,
      CHECK  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_SEED_B  = {{(WIDTH-1){1'b0}}, STRICT_SEED};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev1_q, prev1_d;
   logic [WIDTH-1:0] prev2_q, prev2_d;
   logic             locked_q, locked_d;
   logic             match_q, match_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0] w_sum;
   logic             w_seed_a_ok;
   logic             w_seed_b_ok;

   assign w_sum       = prev1_q + prev2_q;
   assign w_seed_a_ok = !STRICT_SEED || (seq_i == '0);
   assign w_seed_b_ok = !STRICT_SEED || (seq_i == c_ONE);

   always_comb begin
      state_d     = state_q;
      prev1_d     = prev1_q;
      prev2_d     = prev2_q;
      locked_d    = locked_q;
      match_d     = 1'b0;
      err_d       = 1'b0;
      match_cnt_d = match_cnt_q;
      err_cnt_d   = err_cnt_q;
      expected_d  = '0;

      if (seq_valid_i) begin
         case (state_q)
            SEED_A: begin
               if (w_seed_a_ok) begin
                  prev2_d = seq_i;
                  state_d = SEED_B;
               end else begin
                  err_d = 1'b1;
               end
            end
            SEED_B: begin
               if (w_seed_b_ok) begin
                  prev1_d  = seq_i;
                  state_d  = CHECK;
                  locked_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = SEED_A;
               end
            end
            CHECK: begin
               if (seq_i == w_sum) begin
                  match_d = 1'b1;
                  prev2_d = prev1_q;
                  prev1_d = seq_i;
               end else begin
                  // The offending word is dropped; reseeding starts from the next beat.
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  state_d  = SEED_A;
               end
            end
            default: begin
               locked_d = 1'b0;
               state_d  = SEED_A;
            end
         endcase
      end

      if (match_d && (match_cnt_q != c_CNT_MAX)) match_cnt_d = match_cnt_q + 1'b1;
      if (err_d && (err_cnt_q != c_CNT_MAX))     err_cnt_d   = err_cnt_q + 1'b1;

      case (state_d)
         SEED_B:  expected_d = c_SEED_B;
         CHECK:   expected_d = prev1_d + prev2_d;
         default: expected_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SEED_A;
         prev1_q     <= '0;
         prev2_q     <= '0;
         locked_q    <= 1'b0;
         match_q     <= 1'b0;
         err_q       <= 1'b0;
         expected_q  <= '0;
         match_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         prev1_q     <= prev1_d;
         prev2_q     <= prev2_d;
         locked_q    <= locked_d;
         match_q     <= match_d;
         err_q       <= err_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked_o    = locked_q;
   assign match_o     = match_q;
   assign err_o       = err_q;
   assign expected_o  = expected_q;
   assign match_cnt_o = match_cnt_q;
   assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire
